// File: rtl/spk_pkg.sv
// Shared types and constants for the speaker output power/mute sequencer.
// The gain scaling helper lives here so the datapath and any model share one definition.
package spk_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_CLK_WAIT,
        ST_AMP_SETTLE,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN,
        ST_AMP_OFF,
        ST_FAULT
    } spk_seq_state_t;

    localparam int SPK_GAIN_W     = 5;
    localparam int SPK_GAIN_MAX   = 16;
    localparam int SPK_PCM_W      = 16;
    localparam int SPK_GAIN_SHIFT = 4;
    localparam int SPK_PROD_W     = SPK_PCM_W + SPK_GAIN_W + 1;

    // Gain 16 is exactly unity after the shift, so the result always fits in PCM width.
    function automatic logic [SPK_PCM_W-1:0] spk_scale(
        input logic signed [SPK_PCM_W-1:0]  sample,
        input logic        [SPK_GAIN_W-1:0] gain
    );
        logic signed [SPK_PROD_W-1:0] prod;
        prod = SPK_PROD_W'(sample) * SPK_PROD_W'($signed({1'b0, gain}));
        return prod[SPK_PCM_W+SPK_GAIN_SHIFT-1:SPK_GAIN_SHIFT];
    endfunction

endpackage

// File: rtl/spk_output_seq_gain.sv
// Gain stage: multiply/shift into a single output register with valid/ready flow control.
// Outside the pass window inputs are accepted and dropped; a pending output still drains.
module spk_gain_stage
    import spk_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pass_en,
    input  logic                  flush,
    input  logic                  ready_en,
    input  logic [SPK_GAIN_W-1:0] gain,
    input  logic [SPK_PCM_W-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SPK_PCM_W-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic                 out_valid_q, out_valid_d;
    logic [SPK_PCM_W-1:0] out_data_q, out_data_d;

    assign in_ready  = ready_en && (!pass_en || !out_valid_q || out_ready);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (pass_en && in_valid && in_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = spk_scale(in_data, gain);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: rtl/spk_output_seq.sv
// Speaker output sequencer: clock bring-up, amplifier enable, gain ramps and fault handling.
// One shared cycle counter restarts on every state change and on every gain step.
module spk_output_seq
    import spk_pkg::*;
#(
    parameter int LOCK_TIMEOUT     = 4096,
    parameter int SETTLE_CYCLES    = 100_000,
    parameter int RAMP_STEP_CYCLES = 6250,
    parameter int OFF_HOLD         = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clk_locked,
    output logic                 clk_en,
    output logic                 amp_sd_n,
    input  logic [SPK_PCM_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SPK_PCM_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 running,
    output logic                 fault
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + SETTLE_CYCLES + RAMP_STEP_CYCLES + OFF_HOLD + 1);

    spk_seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SPK_GAIN_W-1:0] gain_q, gain_d;
    logic                  clk_en_q, clk_en_d;
    logic                  amp_sd_n_q, amp_sd_n_d;
    logic                  running_q, fault_q;
    logic                  ready_en_q;
    logic                  flush;
    logic                  pass_en;
    logic                  step_done;

    assign pass_en   = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) || (state_q == ST_RAMP_DOWN);
    assign step_done = (cnt_q == CNT_W'(RAMP_STEP_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        gain_d     = gain_q;
        clk_en_d   = clk_en_q;
        amp_sd_n_d = amp_sd_n_q;
        flush      = 1'b0;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d  = ST_CLK_WAIT;
                    clk_en_d = 1'b1;
                end
            end
            ST_CLK_WAIT: begin
                if (stop) begin
                    state_d    = ST_OFF;
                    clk_en_d   = 1'b0;
                    amp_sd_n_d = 1'b0;
                end else if (clk_locked) begin
                    state_d    = ST_AMP_SETTLE;
                    amp_sd_n_d = 1'b1;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                end
            end
            ST_AMP_SETTLE: begin
                if (!clk_locked) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d    = ST_OFF;
                    clk_en_d   = 1'b0;
                    amp_sd_n_d = 1'b0;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_RAMP_UP;
                    gain_d  = '0;
                end
            end
            ST_RAMP_UP: begin
                if (!clk_locked) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d = ST_RAMP_DOWN;
                end else if (gain_q >= SPK_GAIN_W'(SPK_GAIN_MAX)) begin
                    state_d = ST_RUN;
                end else if (step_done) begin
                    gain_d = gain_q + 1'b1;
                    cnt_d  = '0;
                    if (gain_q == SPK_GAIN_W'(SPK_GAIN_MAX - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!clk_locked) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (!clk_locked) begin
                    state_d = ST_FAULT;
                end else if (start && !stop) begin
                    state_d = ST_RAMP_UP;
                end else if (gain_q == '0) begin
                    state_d    = ST_AMP_OFF;
                    amp_sd_n_d = 1'b0;
                end else if (step_done) begin
                    gain_d = gain_q - 1'b1;
                    cnt_d  = '0;
                    if (gain_q == SPK_GAIN_W'(1)) begin
                        state_d    = ST_AMP_OFF;
                        amp_sd_n_d = 1'b0;
                    end
                end
            end
            ST_AMP_OFF: begin
                if (cnt_q == CNT_W'(OFF_HOLD - 1)) begin
                    state_d  = ST_OFF;
                    clk_en_d = 1'b0;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
                if (stop) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
        // Fault entry powers everything down and discards any pending output sample.
        if (state_d == ST_FAULT && state_q != ST_FAULT) begin
            clk_en_d   = 1'b0;
            amp_sd_n_d = 1'b0;
            gain_d     = '0;
            flush      = 1'b1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            gain_q     <= '0;
            clk_en_q   <= 1'b0;
            amp_sd_n_q <= 1'b0;
            running_q  <= 1'b0;
            fault_q    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gain_q     <= gain_d;
            clk_en_q   <= clk_en_d;
            amp_sd_n_q <= amp_sd_n_d;
            running_q  <= (state_d == ST_RUN);
            fault_q    <= (state_d == ST_FAULT);
            ready_en_q <= 1'b1;
        end
    end

    assign clk_en   = clk_en_q;
    assign amp_sd_n = amp_sd_n_q;
    assign running  = running_q;
    assign fault    = fault_q;

    spk_gain_stage u_gain (
        .clk       (clk),
        .rst_n     (rst_n),
        .pass_en   (pass_en),
        .flush     (flush),
        .ready_en  (ready_en_q),
        .gain      (gain_q),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_spk_output_seq.sv
// Directed bench for spk_output_seq with a small clock-generator lock model.
// Lock arrives 13 cycles after clk_en; lock_drop forces it low.
module tb_spk_output_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, clk_locked;
    logic        clk_en, amp_sd_n;
    logic [15:0] in_data;
    logic        in_valid, in_ready;
    logic [15:0] out_data;
    logic        out_valid, out_ready;
    logic        running, fault;
    logic        lock_drop;
    logic [3:0]  lock_cnt;
    int          passCount = 0;
    int          totalCount = 0;

    always #5 clk = ~clk;

    spk_output_seq #(
        .LOCK_TIMEOUT     (64),
        .SETTLE_CYCLES    (32),
        .RAMP_STEP_CYCLES (4),
        .OFF_HOLD         (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .clk_locked (clk_locked),
        .clk_en     (clk_en),
        .amp_sd_n   (amp_sd_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .running    (running),
        .fault      (fault)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              lock_cnt <= 4'd0;
        else if (!clk_en)        lock_cnt <= 4'd0;
        else if (lock_cnt < 4'd13) lock_cnt <= lock_cnt + 4'd1;
    end
    assign clk_locked = (lock_cnt == 4'd13) && !lock_drop;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic s_start, input logic s_stop);
        start = s_start;
        stop  = s_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitAmp();
        for (int i = 0; i < 40 && amp_sd_n !== 1'b1; i++) @(negedge clk);
        checkOutput("amp_on", {31'd0, amp_sd_n}, 32'd1);
    endtask

    task automatic waitRunning();
        for (int i = 0; i < 200 && running !== 1'b1; i++) @(negedge clk);
        checkOutput("reach_run", {31'd0, running}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; lock_drop = 1'b0;
        in_data = 16'h0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_clk_en", {31'd0, clk_en}, 32'd0);
        checkOutput("rst_amp", {31'd0, amp_sd_n}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
        checkOutput("rst_running", {31'd0, running}, 32'd0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("off_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] normal bring-up");
        in_data = 16'h4000; in_valid = 1'b1; out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("clk_en_rise", {31'd0, clk_en}, 32'd1);
        checkOutput("amp_still_off", {31'd0, amp_sd_n}, 32'd0);
        waitAmp();
        repeat (32) @(negedge clk);
        checkOutput("settle_no_valid", {31'd0, out_valid}, 32'd0);
        for (int g = 0; g < 16; g++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                checkOutput("ramp_up_data", {16'd0, out_data}, 32'(g * 16'h0400));
            end
        end
        checkOutput("running_up", {31'd0, running}, 32'd1);
        @(negedge clk);
        checkOutput("unity_data", {16'd0, out_data}, 32'h4000);

        $display("[TB] backpressure");
        out_ready = 1'b0; in_data = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_data", {16'd0, out_data}, 32'h4000);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", {16'd0, out_data}, 32'h1234);

        $display("[TB] stop and rounding");
        applyStimulus(1'b0, 1'b1);
        in_data = 16'hFFFF;
        repeat (33) @(negedge clk);
        checkOutput("neg1_gain8", {16'd0, out_data}, 32'hFFFF);
        in_data = 16'hFFFD;
        @(negedge clk);
        checkOutput("neg3_gain8", {16'd0, out_data}, 32'hFFFE);
        repeat (29) @(negedge clk);
        checkOutput("amp_before_off", {31'd0, amp_sd_n}, 32'd1);
        @(negedge clk);
        checkOutput("amp_off", {31'd0, amp_sd_n}, 32'd0);
        checkOutput("clk_hold", {31'd0, clk_en}, 32'd1);
        checkOutput("last_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("last_data", {16'd0, out_data}, 32'hFFFF);
        @(negedge clk);
        checkOutput("drained", {31'd0, out_valid}, 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("clk_hold_end", {31'd0, clk_en}, 32'd1);
        @(negedge clk);
        checkOutput("clk_off", {31'd0, clk_en}, 32'd0);

        $display("[TB] reversal from ramp-down");
        in_data = 16'h4000;
        applyStimulus(1'b1, 1'b0);
        waitAmp();
        waitRunning();
        applyStimulus(1'b0, 1'b1);
        repeat (33) @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("rev_gain8", {16'd0, out_data}, 32'h2000);
        @(negedge clk);
        checkOutput("rev_gain9", {16'd0, out_data}, 32'h2400);
        checkOutput("rev_amp", {31'd0, amp_sd_n}, 32'd1);
        waitRunning();

        $display("[TB] lock loss");
        lock_drop = 1'b1;
        @(negedge clk);
        checkOutput("ll_fault", {31'd0, fault}, 32'd1);
        checkOutput("ll_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("ll_clk_en", {31'd0, clk_en}, 32'd0);
        checkOutput("ll_amp", {31'd0, amp_sd_n}, 32'd0);
        checkOutput("ll_running", {31'd0, running}, 32'd0);
        lock_drop = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("ll_start_ign", {31'd0, fault}, 32'd1);
        checkOutput("ll_start_clk", {31'd0, clk_en}, 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ll_cleared", {31'd0, fault}, 32'd0);

        $display("[TB] lock timeout");
        lock_drop = 1'b1;
        applyStimulus(1'b1, 1'b0);
        repeat (63) @(negedge clk);
        checkOutput("to_not_yet", {31'd0, fault}, 32'd0);
        checkOutput("to_clk_on", {31'd0, clk_en}, 32'd1);
        @(negedge clk);
        checkOutput("to_fault", {31'd0, fault}, 32'd1);
        checkOutput("to_clk_off", {31'd0, clk_en}, 32'd0);
        checkOutput("to_amp_off", {31'd0, amp_sd_n}, 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("to_cleared", {31'd0, fault}, 32'd0);
        lock_drop = 1'b0;

        $display("[TB] reset mid-ramp and simultaneous requests");
        applyStimulus(1'b1, 1'b0);
        waitAmp();
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mr_clk_en", {31'd0, clk_en}, 32'd0);
        checkOutput("mr_amp", {31'd0, amp_sd_n}, 32'd0);
        checkOutput("mr_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mr_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mr_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mr_off_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mr_off_clk", {31'd0, clk_en}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        waitAmp();
        waitRunning();
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_running", {31'd0, running}, 32'd0);
        checkOutput("both_amp", {31'd0, amp_sd_n}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("both_ramp_down", {16'd0, out_data}, 32'h3C00);

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
